// File: rtl/piso_pkg.sv
// Shared types and line-level constants for the PISO framing transmitter.
// Optional feature macro: PISO_PARITY_EN (adds the PARITY state).
package piso_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef PISO_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } piso_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-MAX counter with synchronous clear/enable and a terminal-count flag.
// o_tc is high while the count sits at MAX-1; an enabled tick there wraps to 0.
module piso_bit_counter #(
    parameter int unsigned MAX = 8,
    localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic Clock,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    assign o_tc = (r_count == CW'(MAX - 1));

    // Count register: reset/clear to zero, wrap at terminal count
    always_ff @(posedge Clock) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out framing transmitter: start bit, data LSB-first,
// optional even-parity bit (macro PISO_PARITY_EN), then STOP_BITS stop bits.
// SO is registered from the next state so each bit appears the cycle its
// state is entered.
module piso_frame_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             SO,
    output logic             busy,
    output logic             frame_done
);

    piso_state_t      r_state;
    piso_state_t      w_state_d;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_d;
    logic             r_so;
    logic             w_so_d;
    logic             w_accept;
    logic             w_data_tc;
    logic             w_stop_tc;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    assign w_accept = load_valid && load_ready;
    assign SO       = r_so;

    piso_bit_counter #(
        .MAX (WIDTH)
    ) u_data_cnt (
        .Clock (Clock),
        .rst   (rst),
        .i_clr (r_state != StData),
        .i_en  (r_state == StData),
        .o_tc  (w_data_tc)
    );

    piso_bit_counter #(
        .MAX (STOP_BITS)
    ) u_stop_cnt (
        .Clock (Clock),
        .rst   (rst),
        .i_clr (r_state != StStop),
        .i_en  (r_state == StStop),
        .o_tc  (w_stop_tc)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StStart;
            StStart: w_state_d = StData;
            StData: begin
                if (w_data_tc) begin
`ifdef PISO_PARITY_EN
                    w_state_d = StParity;
`else
                    w_state_d = StStop;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            StParity: w_state_d = StStop;
`endif
            StStop: begin
                if (w_stop_tc) begin
                    w_state_d = w_accept ? StStart : StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Shift register next value: load on accept, shift right once per DATA cycle
    always_comb begin
        w_shift_d = r_shift;
        if (w_accept) begin
            w_shift_d = data_in;
        end else if (r_state == StData) begin
            w_shift_d = r_shift >> 1;
        end
    end

    // Outputs: status from current state, next line level from next state
    always_comb begin
        busy       = (r_state != StIdle);
        frame_done = (r_state == StStop) && w_stop_tc;
        load_ready = (r_state == StIdle) || frame_done;
        w_so_d     = LINE_IDLE;
        case (w_state_d)
            StStart:  w_so_d = LINE_START;
            StData:   w_so_d = w_shift_d[0];
`ifdef PISO_PARITY_EN
            StParity: w_so_d = r_parity;
`endif
            StStop:   w_so_d = LINE_STOP;
            default:  w_so_d = LINE_IDLE;
        endcase
    end

    // Datapath registers: line output, shift register, captured parity
    always_ff @(posedge Clock) begin
        if (rst) begin
            r_so     <= LINE_IDLE;
            r_shift  <= '0;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_so     <= w_so_d;
            r_shift  <= w_shift_d;
`ifdef PISO_PARITY_EN
            if (w_accept) begin
                r_parity <= ^data_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Self-checking bench for piso_frame_tx against a bit-list frame model.
module tb_piso_frame_tx;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned STOP_BITS = 1;
`ifdef PISO_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned L = 1 + WIDTH + P + STOP_BITS;

    logic             Clock = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             SO;
    logic             busy;
    logic             frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    piso_frame_tx #(
        .WIDTH     (WIDTH),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .Clock      (Clock),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .SO         (SO),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Bit i of the result is the line level in the i-th cycle of the frame.
    function automatic logic [L-1:0] frame_bits(input logic [WIDTH-1:0] d);
        logic [L-1:0] f;
        int           ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            f[1+k] = d[k];
            if (d[k]) ones++;
        end
        if (P == 1) f[1+WIDTH] = (ones % 2) == 1;
        return f;
    endfunction

    task automatic check_idle(input string name);
        n_tests++;
        if ({SO, busy, frame_done, load_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL %s: {SO,busy,done,ready} got %b want 1001", name,
                     {SO, busy, frame_done, load_ready});
        end
    endtask

    // Offer a word while idle; it is accepted at the next edge.
    task automatic send(input logic [WIDTH-1:0] d);
        n_tests++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: load_ready got %b want 1", load_ready);
        end
        load_valid = 1'b1;
        data_in    = d;
        tick();
        load_valid = 1'b0;
    endtask

    // Checks a frame that was accepted at the previous edge.
    // mode 0: inputs quiet, 1: random valid/data noise, 2: valid held high.
    task automatic play_frame(input logic [WIDTH-1:0] d, input int mode, input bit chain,
                              input logic [WIDTH-1:0] nd);
        logic [L-1:0] f;
        logic [2:0]   want;
        f = frame_bits(d);
        for (int i = 0; i < L; i++) begin
            n_tests++;
            if (SO !== f[i]) begin
                n_fail++;
                $display("FAIL so_bit[%0d] data=%h: got %b want %b", i, d, SO, f[i]);
            end
            want = {1'b1, i == L - 1, i == L - 1};
            n_tests++;
            if ({busy, frame_done, load_ready} !== want) begin
                n_fail++;
                $display("FAIL status[%0d] {busy,done,ready}: got %b want %b", i,
                         {busy, frame_done, load_ready}, want);
            end
            if (i == L - 1) begin
                load_valid = chain;
                data_in    = nd;
            end else if (mode == 1) begin
                load_valid = 1'($urandom);
                data_in    = WIDTH'($urandom);
            end else if (mode == 2) begin
                load_valid = 1'b1;
                data_in    = nd;
            end
            tick();
        end
        load_valid = 1'b0;
        if (!chain) check_idle("post_frame");
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = WIDTH'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("reset_hold");
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();
        check_idle("reset_release");
    endtask

    task automatic test_single_frame();
        send(8'hA5);
        play_frame(8'hA5, 0, 1'b0, '0);
    endtask

    task automatic test_parity();
`ifdef PISO_PARITY_EN
        send(8'hA5);
        play_frame(8'hA5, 0, 1'b0, '0);
        send(8'h07);
        play_frame(8'h07, 0, 1'b0, '0);
`endif
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        int               gap;
        for (int n = 0; n < 20; n++) begin
            d = WIDTH'($urandom);
            send(d);
            play_frame(d, 0, 1'b0, '0);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                check_idle("gap_idle");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        send(8'hFF);
        play_frame(8'hFF, 2, 1'b1, 8'h00);
        play_frame(8'h00, 0, 1'b0, '0);
        cur = WIDTH'($urandom);
        send(cur);
        for (int n = 0; n < 5; n++) begin
            nxt = WIDTH'($urandom);
            play_frame(cur, 0, n != 4, nxt);
            cur = nxt;
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d;
        for (int n = 0; n < 4; n++) begin
            d = WIDTH'($urandom);
            send(d);
            play_frame(d, 1, 1'b0, '0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [WIDTH-1:0] d;
        logic [L-1:0]     f;
        d = 8'h5C;
        f = frame_bits(d);
        send(d);
        // Cycle 4 of the frame carries data bit 3.
        for (int i = 0; i <= 4; i++) begin
            n_tests++;
            if (SO !== f[i]) begin
                n_fail++;
                $display("FAIL midrst_bit[%0d]: got %b want %b", i, SO, f[i]);
            end
            if (i < 4) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst_after");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("midrst_quiet");
        end
        d = 8'h3B;
        send(d);
        play_frame(d, 0, 1'b0, '0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        test_reset();
        test_single_frame();
        test_parity();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Parallel-in, serial-out framing transmitter that sits directly upstream of the serial-in parallel-out shift register and drives its `SI` input. It accepts a WIDTH-bit word over a valid/ready handshake, then emits one bit per clock on `SO`: a start bit, the data LSB-first, an optional parity bit, and stop bits. Between frames the line holds its idle level.

## Interface
- `WIDTH`, default 8: data bits per frame (legal range 2..32).
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).
- `Clock`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high (sampled on `Clock` posedge).
- `data_in`  in  WIDTH: word to transmit; sampled only on an accepted load.
- `load_valid`  in  1: producer offers `data_in`.
- `load_ready`  out  1: block can accept a word this cycle.
- `SO`  out  1: serial line to downstream `SI`; registered.
- `busy`  out  1: a frame is in progress (any non-IDLE state).
- `frame_done`  out  1: one-cycle pulse during the final stop-bit cycle.

## Operation
- Accept: `load_valid && load_ready` at a posedge. `data_in` is captured into the shift register. `data_in` is ignored at all other times.
- Line levels: idle = 1, start = 0, stop = 1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after 1 cycle.
  - DATA -> PARITY (or STOP if parity is compiled out) after WIDTH cycles.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if a word is accepted in the last stop cycle, otherwise STOP -> IDLE.
- DATA: `SO` = shift-register bit 0. The register shifts right once per DATA cycle; the bit counter runs 0..WIDTH-1.
- Parity: even parity. The parity bit is the XOR of all captured data bits, so the total number of ones across data+parity is even.
- `load_ready` = 1 in IDLE and in the final STOP cycle; 0 otherwise. This permits back-to-back frames with no idle gap.
- `load_valid` while `load_ready` = 0: no effect. The producer must hold the word until it is accepted.
- Reset mid-frame: the frame is abandoned. On the next cycle `SO` = 1 and the state is IDLE; no `frame_done` pulse is produced.
- `rst` asserted in the same cycle as `load_valid`: reset wins and the word is not accepted.

## Timing
- Reset values (cycle after `rst` is sampled high): `SO`=1, `busy`=0, `frame_done`=0, `load_ready`=1, counter=0, state=IDLE.
- Accept at edge N: `SO`=0 (start bit) from edge N+1; data bit 0 from N+2; data bit WIDTH-1 from N+1+WIDTH.
- Frame length L = 1 + WIDTH + P + STOP_BITS cycles, with P = 1 if parity is compiled in, else 0. For the defaults without parity, L = 10.
- `frame_done` and `load_ready` (from STOP) are both high in cycle N+L. If no new word is accepted, `SO`=1 and `busy`=0 from N+L+1.
- `busy` is high from N+1 through N+L inclusive.

## Configuration
- `PISO_PARITY_EN` defined: the PARITY state exists, P = 1, and an even-parity bit follows the data.
- `PISO_PARITY_EN` undefined: no parity logic or state; DATA goes directly to STOP and P = 0.

## Structure
- Package `piso_pkg`: state enum `piso_state_t`; constants `LINE_IDLE`=1, `LINE_START`=0, `LINE_STOP`=1.
- Sub-module `piso_bit_counter`: a parameterised modulo counter with clear and enable, and a terminal-count flag. One instance counts DATA bits; a second counts STOP bits.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `load_valid`=1 -> `SO`=1, `busy`=0, `load_ready`=1, no accept.
- Single frame: WIDTH=8, no parity, `data_in`=8'hA5 -> `SO` sequence 0,1,0,1,0,0,1,0,1,1; `frame_done` pulses on the 10th bit; `busy` high for exactly 10 cycles.
- Parity (`PISO_PARITY_EN`): 8'hA5 gives parity 0 and 8'h07 gives parity 1 -> 11-bit frames; the bit after data bit 7 matches the expected parity.
- Back-to-back: hold `load_valid` high with 8'hFF then 8'h00 -> the second start bit immediately follows the first stop bit; no idle cycle.
- Backpressure: toggle `data_in` while `busy` -> transmitted bits match only the value captured at accept; `load_ready`=0 mid-frame.
- Reset mid-frame: assert `rst` during data bit 3 -> next cycle `SO`=1 and IDLE; no `frame_done`; a fresh load afterwards transmits correctly.
